aes128_iter_enc: RTL

- Iterative AES-128 encryption core with a parametrised number of S-box lanes. It replaces the byte-serial encrypt flow.
- Loads a full 128-bit plaintext and key in one handshake. Expands round keys on the fly and runs 10 rounds. Returns the ciphertext on a valid/ready output port.
- Sits between the message buffer and the UART/AXI output path.

---
 rtl/aes128_iter_enc.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_iter_enc.sv
// aes128_iter_enc: iterative AES-128 encryption core.
// - Takes a full 128-bit plaintext and key in one handshake and runs 10 rounds.
// - Round keys are expanded on the fly.
// - SubBytes is spread over LANES registered S-box lanes; the key schedule has 4 lanes of its own.
// - Optional feature: define AES128_ITER_ENC_ABORT_EN to add an 'abort' input.
//   Asserting abort during SUB or MIX cancels the block in flight.

// One registered S-box lane: the combinational S-box (multiplicative inverse
// in GF(2^8) followed by the affine map) feeding an output register with enable.
module aes128_iter_enc_sbox (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] dout_q;
  logic [7:0] dout_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse is x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0 naturally).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = x;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Next output value: new S-box result when enabled, otherwise hold.
  always_comb begin
    dout_d = dout_q;
    if (en) dout_d = sbox(din);
  end

  // Output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dout_q <= 8'h00;
    else          dout_q <= dout_d;
  end

  assign dout = dout_q;
endmodule

module aes128_iter_enc #(
  parameter int LANES = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
`ifdef AES128_ITER_ENC_ABORT_EN
  ,
  input  logic         abort
`endif
);
  localparam int GROUPS = 16 / LANES;
  localparam int N = GROUPS + 1;
  localparam logic [4:0] SUB_LAST = 5'(N - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes128_iter_enc: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [4:0]   sub_cnt_q, sub_cnt_d;
  logic         busy_q, busy_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] ct_q, ct_d;

  // Byte i of a block (byte 0 in bits [127:120]).
  function automatic logic [7:0] get_b(input logic [127:0] s, input logic [3:0] i);
    return s[{~i, 3'b000} +: 8];
  endfunction

  function automatic logic [127:0] set_b(input logic [127:0] s, input logic [3:0] i,
                                         input logic [7:0] v);
    logic [127:0] o;
    o = s;
    o[{~i, 3'b000} +: 8] = v;
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // ShiftRows followed by MixColumns (MixColumns skipped in the final round).
  function automatic logic [127:0] shift_mix(input logic [127:0] s, input logic last);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_b(s, 4'(4 * c));
      a1 = get_b(s, 4'(4 * ((c + 1) % 4) + 1));
      a2 = get_b(s, 4'(4 * ((c + 2) % 4) + 2));
      a3 = get_b(s, 4'(4 * ((c + 3) % 4) + 3));
      if (last) begin
        o = set_b(o, 4'(4 * c),     a0);
        o = set_b(o, 4'(4 * c + 1), a1);
        o = set_b(o, 4'(4 * c + 2), a2);
        o = set_b(o, 4'(4 * c + 3), a3);
      end else begin
        o = set_b(o, 4'(4 * c),     xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3);
        o = set_b(o, 4'(4 * c + 1), a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3);
        o = set_b(o, 4'(4 * c + 2), a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3);
        o = set_b(o, 4'(4 * c + 3), xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3));
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // sw is SubWord(RotWord(w3)) captured by the key lanes in SUB cycle 0.
  function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [31:0] sw,
                                           input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sw ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // State S-box lanes: in SUB cycle i, lane l substitutes byte LANES*i + l.
  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];
  logic       sub_en;
  assign sub_en = (fsm_q == SUB);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_in[gi] = get_b(state_q, 4'(int'(sub_cnt_q) * LANES + gi));
    aes128_iter_enc_sbox u_sbox (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (sub_en),
      .din     (lane_in[gi]),
      .dout    (lane_out[gi])
    );
  end

  // Write-back view: byte b takes its lane result the cycle after its group was fed.
  logic [127:0] sub_state;
  for (genvar gi = 0; gi < 16; gi++) begin : g_wb
    assign sub_state[8 * (15 - gi) +: 8] = (sub_cnt_q == 5'(gi / LANES + 1)) ?
                                           lane_out[gi % LANES] : state_q[8 * (15 - gi) +: 8];
  end

  // Key-schedule lanes: load RotWord(w3) in SUB cycle 0, then hold until MIX.
  logic [31:0] rot_w3;
  logic [31:0] key_sw;
  logic        key_en;
  assign rot_w3 = {rk_q[23:0], rk_q[31:24]};
  assign key_en = (fsm_q == SUB) && (sub_cnt_q == 5'd0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_key_lane
    aes128_iter_enc_sbox u_sbox (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (key_en),
      .din     (rot_w3[8 * (3 - gi) +: 8]),
      .dout    (key_sw[8 * (3 - gi) +: 8])
    );
  end

  logic [127:0] rk_next;
  logic         accept;
  assign rk_next = next_rk(rk_q, key_sw, rcon(round_q));
  assign accept  = (fsm_q == IDLE) && in_valid && in_ready_q;

  // Next-state and datapath control; in_ready is delayed one cycle after leaving DONE.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rk_d        = rk_q;
    round_d     = round_q;
    sub_cnt_d   = sub_cnt_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    ct_d        = ct_q;
    in_ready_d  = (fsm_q == IDLE) && !accept;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d   = plaintext ^ key;
          rk_d      = key;
          round_d   = 4'd1;
          sub_cnt_d = 5'd0;
          busy_d    = 1'b1;
          fsm_d     = SUB;
        end
      end
      SUB: begin
        state_d = sub_state;
        if (sub_cnt_q == SUB_LAST) begin
          sub_cnt_d = 5'd0;
          fsm_d     = MIX;
        end else begin
          sub_cnt_d = sub_cnt_q + 5'd1;
        end
      end
      MIX: begin
        state_d = shift_mix(state_q, round_q == 4'd10) ^ rk_next;
        rk_d    = rk_next;
        if (round_q == 4'd10) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = SUB;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          ct_d        = state_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          round_d     = 4'd0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
`ifdef AES128_ITER_ENC_ABORT_EN
    if (abort && (fsm_q == SUB || fsm_q == MIX)) begin
      fsm_d     = IDLE;
      state_d   = '0;
      rk_d      = '0;
      round_d   = 4'd0;
      sub_cnt_d = 5'd0;
      busy_d    = 1'b0;
    end
`endif
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      round_q     <= 4'd0;
      sub_cnt_q   <= 5'd0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ct_q        <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      round_q     <= round_d;
      sub_cnt_q   <= sub_cnt_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ct_q        <= ct_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
  assign busy       = busy_q;
endmodule
